// File: rtl/fifo_rd_req_to_vr_adapter.sv
// fifo_rd_req_to_vr_adapter
// Turns a request-style FIFO read port (data one cycle after the request)
// into a valid/ready stream through a small circular buffer.
// Requests are credit-limited, so a stalled consumer never causes a returned
// word to be lost.
// Optional statistics counters: define FIFO_RD_ADP_STAT_EN.
module fifo_rd_req_to_vr_adapter #(
    parameter int DATA_WD  = 32,
    parameter int BUF_SIZE = 2,
    parameter int CNT_WD   = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clr_i,
    input  logic                             fifo_rd_ept_i,
    output logic                             fifo_rd_val_o,
    input  logic                             fifo_rd_val_i,
    input  logic [DATA_WD-1:0]               fifo_rd_dat_i,
    output logic                             m_val_o,
    output logic [DATA_WD-1:0]               m_dat_o,
    input  logic                             m_rdy_i,
    output logic [$clog2(BUF_SIZE+1)-1:0]    buf_usd_o,
    output logic [CNT_WD-1:0]                stat_cnt_o,
    output logic [CNT_WD-1:0]                stat_stl_o
);

    localparam int CW = $clog2(BUF_SIZE + 1);
    localparam int PW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_SIZE - 1);
    localparam logic [CW:0]   BUF_LIM  = (CW + 1)'(BUF_SIZE);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               infl_q, infl_d;
    logic [PW-1:0]      wp_q, wp_d;
    logic [PW-1:0]      rp_q, rp_d;
    logic [DATA_WD-1:0] mem_q [BUF_SIZE];

    logic               pop;
    logic               push;
    logic [CW:0]        credit;

    // Handshake terms, credit check and stream outputs
    always_comb begin
        m_val_o       = (cnt_q != '0) && !clr_i;
        pop           = m_val_o && m_rdy_i;
        push          = fifo_rd_val_i && !clr_i;
        // one bit wider than cnt_q: occupancy plus in-flight can reach BUF_SIZE+1
        credit        = {1'b0, cnt_q} + (CW + 1)'(infl_q) - (CW + 1)'(pop);
        fifo_rd_val_o = !clr_i && !fifo_rd_ept_i && (credit < BUF_LIM);
        m_dat_o       = mem_q[rp_q];
        buf_usd_o     = cnt_q;
    end

    // Next-state for pointers, occupancy and in-flight flag
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        infl_d = fifo_rd_val_o;
        if (clr_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            infl_q <= 1'b0;
            wp_q   <= '0;
            rp_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
        end
    end

    // Buffer storage; reset only so that m_dat_o reads 0 while in reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < BUF_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wp_q] <= fifo_rd_dat_i;
        end
    end

`ifdef FIFO_RD_ADP_STAT_EN
    logic [CNT_WD-1:0] stat_cnt_q, stat_cnt_d;
    logic [CNT_WD-1:0] stat_stl_q, stat_stl_d;

    // Saturating beat and stall counters; clear wins over increment
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        stat_stl_d = stat_stl_q;
        if (clr_i) begin
            stat_cnt_d = '0;
            stat_stl_d = '0;
        end else begin
            if (pop && (stat_cnt_q != '1)) begin
                stat_cnt_d = stat_cnt_q + CNT_WD'(1);
            end
            if (m_val_o && !m_rdy_i && (stat_stl_q != '1)) begin
                stat_stl_d = stat_stl_q + CNT_WD'(1);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_cnt_q <= '0;
            stat_stl_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            stat_stl_q <= stat_stl_d;
        end
    end

    assign stat_cnt_o = stat_cnt_q;
    assign stat_stl_o = stat_stl_q;
`else
    assign stat_cnt_o = '0;
    assign stat_stl_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_req_to_vr_adapter.sv
// Directed bench for fifo_rd_req_to_vr_adapter: a 2-deep instance (a_*) and a
// 3-deep instance (b_*), each fed by a small request-style FIFO model.
// Statistics expectations follow FIFO_RD_ADP_STAT_EN.
module tb_fifo_rd_req_to_vr_adapter;

`ifdef FIFO_RD_ADP_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // instance A (BUF_SIZE=2)
    logic        clr_a = 1'b0, rdy_a = 1'b0;
    logic        a_ept, a_req, a_rvld, a_mval;
    logic [31:0] a_rdat, a_mdat;
    logic [1:0]  a_usd;
    logic [15:0] a_scnt, a_sstl;
    logic [31:0] fa_mem [64];
    int          fa_wr = 0, fa_rd = 0;

    // instance B (BUF_SIZE=3)
    logic        clr_b = 1'b0, rdy_b = 1'b0;
    logic        b_ept, b_req, b_rvld, b_mval;
    logic [31:0] b_rdat, b_mdat;
    logic [1:0]  b_usd;
    logic [15:0] b_scnt, b_sstl;
    logic [31:0] fb_mem [64];
    int          fb_wr = 0, fb_rd = 0;

    fifo_rd_req_to_vr_adapter #(.DATA_WD(32), .BUF_SIZE(2), .CNT_WD(16)) u_a (
        .clk(clk), .rstn(rstn), .clr_i(clr_a), .fifo_rd_ept_i(a_ept),
        .fifo_rd_val_o(a_req), .fifo_rd_val_i(a_rvld), .fifo_rd_dat_i(a_rdat),
        .m_val_o(a_mval), .m_dat_o(a_mdat), .m_rdy_i(rdy_a), .buf_usd_o(a_usd),
        .stat_cnt_o(a_scnt), .stat_stl_o(a_sstl)
    );

    fifo_rd_req_to_vr_adapter #(.DATA_WD(32), .BUF_SIZE(3), .CNT_WD(16)) u_b (
        .clk(clk), .rstn(rstn), .clr_i(clr_b), .fifo_rd_ept_i(b_ept),
        .fifo_rd_val_o(b_req), .fifo_rd_val_i(b_rvld), .fifo_rd_dat_i(b_rdat),
        .m_val_o(b_mval), .m_dat_o(b_mdat), .m_rdy_i(rdy_b), .buf_usd_o(b_usd),
        .stat_cnt_o(b_scnt), .stat_stl_o(b_sstl)
    );

    // FIFO models: data one cycle after the request, flushed by reset
    assign a_ept = (fa_wr == fa_rd);
    assign b_ept = (fb_wr == fb_rd);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rvld <= 1'b0;
            a_rdat <= '0;
            fa_rd  <= fa_wr;
        end else begin
            a_rvld <= a_req;
            if (a_req) begin
                a_rdat <= fa_mem[fa_rd];
                fa_rd  <= fa_rd + 1;
            end
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_rvld <= 1'b0;
            b_rdat <= '0;
            fb_rd  <= fb_wr;
        end else begin
            b_rvld <= b_req;
            if (b_req) begin
                b_rdat <= fb_mem[fb_rd];
                fb_rd  <= fb_rd + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        fa_mem[fa_wr] = w;
        fa_wr++;
    endtask

    task automatic push_b(input logic [31:0] w);
        fb_mem[fb_wr] = w;
        fb_wr++;
    endtask

    // advance to 2 time units after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int ndone;
        int maxu;

        // reset values
        repeat (3) nxt();
        #1;
        check("rst_a_req", a_req, 0);
        check("rst_a_mval", a_mval, 0);
        check("rst_a_mdat", a_mdat, 0);
        check("rst_a_usd", a_usd, 0);
        check("rst_a_scnt", a_scnt, 0);
        check("rst_a_sstl", a_sstl, 0);
        check("rst_b_mval", b_mval, 0);
        check("rst_b_usd", b_usd, 0);
        rstn = 1'b1;
        nxt();

        // 1: continuous stream of 8 words, consumer always ready
        for (int k = 0; k <= 10; k++) begin
            nxt();
            if (k == 0) for (int i = 1; i <= 8; i++) push_a(32'(i));
            rdy_a = 1'b1;
            #1;
            check("t1_req", a_req, (k <= 7));
            check("t1_mval", a_mval, (k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) check("t1_mdat", a_mdat, 64'(k - 1));
            check("t1_usd", a_usd, (k >= 2 && k <= 9) ? 1 : 0);
        end

        // clear statistics while idle
        nxt();
        clr_a = 1'b1;
        #1;
        check("clr_idle_mval", a_mval, 0);
        nxt();
        clr_a = 1'b0;

        // 2: backpressure, 6 words, ready low for d1..d10
        for (int k = 0; k <= 17; k++) begin
            nxt();
            if (k == 0) for (int i = 0; i < 6; i++) push_a(32'h11 + 32'(i));
            rdy_a = (k == 0 || k >= 11);
            #1;
            check("t2_req", a_req, (k <= 1) || (k >= 11 && k <= 14));
            check("t2_mval", a_mval, (k >= 2 && k <= 16));
            if (k >= 2 && k <= 10) check("t2_mdat_hold", a_mdat, 32'h11);
            if (k >= 11 && k <= 16) check("t2_mdat", a_mdat, 64'(32'h11 + 32'(k - 11)));
            check("t2_usd", a_usd, (k <= 1 || k == 17) ? 0 : (k == 2 || k >= 12) ? 1 : 2);
        end
        check("t2_scnt", a_scnt, STAT ? 6 : 0);
        check("t2_sstl", a_sstl, STAT ? 9 : 0);

        // 3: empty source for 20 cycles, then a single word
        for (int k = 0; k < 20; k++) begin
            nxt();
            #1;
            check("t3_req_empty", a_req, 0);
            check("t3_mval_empty", a_mval, 0);
        end
        nxt();
        push_a(32'hA5);
        #1;
        check("t3_req", a_req, 1);
        nxt();
        #1;
        check("t3_req_after", a_req, 0);
        check("t3_mval_early", a_mval, 0);
        nxt();
        #1;
        check("t3_mval", a_mval, 1);
        check("t3_mdat", a_mdat, 32'hA5);
        nxt();
        #1;
        check("t3_mval_done", a_mval, 0);

        // 4: clear while one word is buffered and another is returning
        nxt();
        rdy_a = 1'b0;
        push_a(32'h31);
        push_a(32'h32);
        #1;
        check("t4_req0", a_req, 1);
        nxt();
        #1;
        check("t4_req1", a_req, 1);
        check("t4_mval1", a_mval, 0);
        nxt();
        rdy_a = 1'b1;
        clr_a = 1'b1;
        push_a(32'h33);
        #1;
        check("t4_rvld_clr", a_rvld, 1);
        check("t4_usd_clr", a_usd, 1);
        check("t4_mval_clr", a_mval, 0);
        check("t4_req_clr", a_req, 0);
        check("t4_scnt_pre", a_scnt, STAT ? 7 : 0);
        check("t4_sstl_pre", a_sstl, STAT ? 9 : 0);
        nxt();
        clr_a = 1'b0;
        #1;
        check("t4_usd_post", a_usd, 0);
        check("t4_mval_post", a_mval, 0);
        check("t4_req_resume", a_req, 1);
        check("t4_scnt_post", a_scnt, 0);
        check("t4_sstl_post", a_sstl, 0);
        nxt();
        #1;
        check("t4_mval_wait", a_mval, 0);
        nxt();
        #1;
        check("t4_mval", a_mval, 1);
        check("t4_mdat", a_mdat, 32'h33);
        nxt();
        #1;
        check("t4_usd_end", a_usd, 0);

        // 5: 3-deep buffer, 12 words, ready toggling every cycle
        ndone = 0;
        maxu = 0;
        for (int k = 0; k < 40; k++) begin
            nxt();
            if (k == 0) for (int i = 0; i < 12; i++) push_b(32'h41 + 32'(i));
            rdy_b = (k % 2 == 0);
            #1;
            if (int'(b_usd) > maxu) maxu = int'(b_usd);
            if (b_mval && rdy_b) begin
                check("t5_order", b_mdat, 64'(32'h41 + 32'(ndone)));
                ndone++;
            end
        end
        check("t5_count", ndone, 12);
        check("t5_max_usd", maxu, 3);
        check("t5_usd_end", b_usd, 0);
        check("t5_mval_end", b_mval, 0);

        // 6: asynchronous reset with two words buffered and one in flight
        nxt();
        rdy_b = 1'b0;
        push_b(32'h51);
        push_b(32'h52);
        push_b(32'h53);
        #1;
        check("t6_req0", b_req, 1);
        nxt();
        nxt();
        nxt();
        #1;
        check("t6_usd_pre", b_usd, 2);
        check("t6_infl_pre", b_rvld, 1);
        check("t6_mdat_pre", b_mdat, 32'h51);
        rstn = 1'b0;
        #1;
        check("t6_b_req", b_req, 0);
        check("t6_b_mval", b_mval, 0);
        check("t6_b_mdat", b_mdat, 0);
        check("t6_b_usd", b_usd, 0);
        check("t6_b_scnt", b_scnt, 0);
        check("t6_b_sstl", b_sstl, 0);
        check("t6_a_mval", a_mval, 0);
        check("t6_a_mdat", a_mdat, 0);
        nxt();
        nxt();
        rstn = 1'b1;
        nxt();
        #1;
        check("t6_usd_rel", b_usd, 0);
        check("t6_mval_rel", b_mval, 0);
        check("t6_req_rel", b_req, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_req_to_vr_adapter.md
Name: fifo_rd_req_to_vr_adapter

Overview:
- Sits at the read end of the team's request-style FIFOs. On those FIFOs a read request is raised and the data comes back exactly one cycle later.
- The adapter issues the read requests itself, collects the returned words in a small circular buffer, and presents them as a valid/ready stream to downstream logic.
- It never over-requests, so no returned word is lost when downstream stalls.
- Steady-state throughput is one word per cycle when BUF_SIZE >= 2.

Parameters:
- DATA_WD, 32, width of the FIFO data word and of the stream data.
- BUF_SIZE, 2, number of entries in the output buffer; minimum 1; need not be a power of two.
- CNT_WD, 16, width of the statistics counters.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- clr_i  input  1  synchronous clear: drops buffered and returning data.
- fifo_rd_ept_i  input  1  FIFO empty flag; reflects all requests issued up to the previous cycle.
- fifo_rd_val_o  output  1  read request to the FIFO.
- fifo_rd_val_i  input  1  FIFO returned-data valid; one cycle after the request.
- fifo_rd_dat_i  input  DATA_WD  FIFO returned data.
- m_val_o  output  1  stream valid.
- m_dat_o  output  DATA_WD  stream data.
- m_rdy_i  input  1  stream ready.
- buf_usd_o  output  log2(BUF_SIZE)+1  buffer occupancy.
- stat_cnt_o  output  CNT_WD  accepted-beat count (optional feature).
- stat_stl_o  output  CNT_WD  stall-cycle count (optional feature).

Behaviour:
Reset values (rstn low):
- All outputs 0.
- Buffer pointers, occupancy counter cnt_r, in-flight flag infl_r and statistics counters cleared.
- Buffer contents are don't-care.

Definitions:
- pop = m_val_o && m_rdy_i.
- push = fifo_rd_val_i && !clr_i.

Request (combinational):
- fifo_rd_val_o = !clr_i && !fifo_rd_ept_i && (cnt_r + infl_r - pop < BUF_SIZE).
- The term is evaluated at width log2(BUF_SIZE)+2, so it cannot underflow.
- This is a combinational path from m_rdy_i to fifo_rd_val_o, and it is required for full throughput at BUF_SIZE=2.

In-flight tracking:
- infl_r <= fifo_rd_val_o every cycle.
- The FIFO latency is fixed at 1 cycle, so fifo_rd_val_i is expected exactly when infl_r is 1.

Buffer:
- Circular storage of BUF_SIZE entries, write pointer wp_r, read pointer rp_r.
- On push: buf[wp_r] <= fifo_rd_dat_i, and wp_r advances.
- On pop: rp_r advances.
- Each pointer wraps from BUF_SIZE-1 to 0.
- cnt_r is +1 on push only, -1 on pop only, unchanged on both or neither.

Stream outputs:
- m_val_o = (cnt_r != 0) && !clr_i.
- m_dat_o = buf[rp_r]. No bypass.
- Latency: request in cycle t, data returns in t+1, m_val_o rises in t+2.
- m_dat_o and m_val_o stay stable while m_val_o && !m_rdy_i.

buf_usd_o:
- Equals cnt_r.

Boundary conditions:
- FIFO empty: no request is issued, and a pending m_val_o drains normally.
- Buffer full with nothing in flight: no request unless pop occurs in the same cycle.
- Push and pop in the same cycle with cnt_r=BUF_SIZE cannot happen, because of the credit rule.
- clr_i high:
  - Request forced to 0 and m_val_o forced to 0, so no transfer occurs.
  - Any fifo_rd_val_i arriving in that cycle is discarded.
  - Next cycle: cnt_r=0, wp_r=rp_r=0, infl_r=0.
  - clr_i held for multiple cycles keeps the block idle.
- Reset asserted mid-operation: state cleared asynchronously. Any in-flight FIFO return is the FIFO owner's concern, because the FIFO is reset with the same rstn.

Optional Feature:
Macro FIFO_RD_ADP_STAT_EN.

When defined:
- stat_cnt_o increments on every pop.
- stat_stl_o increments on every cycle with m_val_o && !m_rdy_i.
- Both counters saturate at all-ones.
- Both counters clear on reset and on clr_i; the clear has priority over the increment.

When undefined:
- stat_cnt_o and stat_stl_o are tied to 0, and no counter flops are instantiated.
- Port list is identical in both builds.

Test Plan:
1. Continuous stream: FIFO preloaded with 8 words 0x1..0x8, m_rdy_i=1 throughout, BUF_SIZE=2.
   - Expected: fifo_rd_val_o high for 8 consecutive cycles.
   - Expected: m_val_o high for 8 consecutive cycles starting 2 cycles after the first request, data 0x1..0x8 in order, final buf_usd_o=0.
2. Backpressure: FIFO holds 6 words, m_rdy_i=0 for 10 cycles, then 1.
   - Expected: exactly 2 requests issued, buf_usd_o=2, m_dat_o held at the first word.
   - Expected after release: all 6 words delivered in order with no loss or duplication.
   - Expected with the optional feature: stat_stl_o=9 (10 cycles minus the 1 cycle before m_val_o first rises), stat_cnt_o=6.
3. Empty source: FIFO empty for 20 cycles, then one word 0xA5 is written.
   - Expected: fifo_rd_val_o=0 while empty.
   - Expected: one request, then m_val_o with 0xA5 2 cycles after that request.
4. Clear with data in flight: clr_i pulsed for 1 cycle in the same cycle fifo_rd_val_i=1, while buf_usd_o=1.
   - Expected: m_val_o=0 during the pulse and the returned word is dropped.
   - Expected next cycle: buf_usd_o=0; requests resume if the FIFO is non-empty.
5. Odd depth and wrap: BUF_SIZE=3, 12 words, m_rdy_i toggling 1/0 every cycle.
   - Expected: pointers wrap 2 -> 0 correctly, order preserved, buf_usd_o never exceeds 3.
6. Async reset mid-stream: rstn asserted with buf_usd_o=2 and infl_r=1.
   - Expected: all outputs 0 immediately, and buf_usd_o=0 after release.
   - With the optional feature: both statistics counters read 0.
